// File: rtl/ex_wb_dest_pipe_pkg.sv
// ex_wb_dest_pipe_pkg: destination-select encoding, default address width and slot layout.
package ex_wb_dest_pipe_pkg;
   localparam int REG_AW_DEF = 5;
   typedef enum logic [1:0] {
      DST_RT   = 2'b00,
      DST_RD   = 2'b01,
      DST_LINK = 2'b10,
      DST_NONE = 2'b11
   } dst_sel_e;
   typedef struct packed {
      logic [REG_AW_DEF-1:0] addr;
      logic                  wr;
   } slot_t;
endpackage

// File: rtl/ex_wb_dest_pipe_dest_slot.sv
// dest_slot: one in-flight destination register {addr, wr}; clear beats hold beats load.
module dest_slot #(
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          hold,
   input  logic          clear,
   input  logic [AW-1:0] d_addr,
   input  logic          d_wr,
   output logic [AW-1:0] addr,
   output logic          wr
);
   logic [AW-1:0] addr_d, addr_q;
   logic          wr_d, wr_q;
   always_comb begin
      addr_d = clear ? '0 : hold ? addr_q : d_addr;
      wr_d   = clear ? 1'b0 : hold ? wr_q : d_wr;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q <= '0;
         wr_q   <= 1'b0;
      end else begin
         addr_q <= addr_d;
         wr_q   <= wr_d;
      end
   end
   assign addr = addr_q;
   assign wr   = wr_q;
endmodule

// File: rtl/ex_wb_dest_pipe.sv
// ex_wb_dest_pipe: EX destination select carried through NSTAGE slots to the register-file write port.
// Optional LINK_DEST_EN: dst_sel=10 selects LINK_REG instead of acting as no-write.
module ex_wb_dest_pipe
   import ex_wb_dest_pipe_pkg::*;
#(
   parameter int REG_AW   = REG_AW_DEF,
   parameter int NSTAGE   = 3,
   parameter int LINK_REG = 31
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              issue_valid,
   input  logic              regwrite,
   input  logic [1:0]        dst_sel,
   input  logic [REG_AW-1:0] rt,
   input  logic [REG_AW-1:0] rd,
   input  logic              stall,
   input  logic              flush,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   output logic [REG_AW-1:0] ex_wbadd,
   output logic [REG_AW-1:0] wbadd,
   output logic              wb_en,
   output logic [NSTAGE-1:0] hit_rs,
   output logic [NSTAGE-1:0] hit_rt
);
   logic [REG_AW-1:0] sel_addr;
   logic              sel_wr;
   logic [REG_AW-1:0] s_addr [NSTAGE];
   logic [NSTAGE-1:0] s_wr;
`ifdef LINK_DEST_EN
   always_comb begin
      sel_addr = dst_sel == DST_RD ? rd : dst_sel == DST_LINK ? REG_AW'(LINK_REG) : rt;
      sel_wr   = issue_valid & regwrite & (dst_sel != DST_NONE) & (|sel_addr);
   end
`else
   logic unused_link;
   assign unused_link = ^LINK_REG;
   always_comb begin
      sel_addr = dst_sel == DST_RD ? rd : rt;
      sel_wr   = issue_valid & regwrite & (dst_sel == DST_RT || dst_sel == DST_RD) & (|sel_addr);
   end
`endif
   assign ex_wbadd = sel_addr;
   for (genvar i = 0; i < NSTAGE; i++) begin : g_slot
      if (i == 0) begin : g_head
         dest_slot #(.AW(REG_AW)) u_slot (
            .clk(clk), .rst_n(rst_n), .hold(stall), .clear(flush),
            .d_addr(sel_addr), .d_wr(sel_wr), .addr(s_addr[i]), .wr(s_wr[i])
         );
      end else begin : g_tail
         dest_slot #(.AW(REG_AW)) u_slot (
            .clk(clk), .rst_n(rst_n), .hold(stall), .clear(1'b0),
            .d_addr(s_addr[i-1]), .d_wr(s_wr[i-1]), .addr(s_addr[i]), .wr(s_wr[i])
         );
      end
      // register 0 never counts as a producer
      assign hit_rs[i] = s_wr[i] & (s_addr[i] == id_rs) & (|id_rs);
      assign hit_rt[i] = s_wr[i] & (s_addr[i] == id_rt) & (|id_rt);
   end
   assign wbadd = s_addr[NSTAGE-1];
   assign wb_en = s_wr[NSTAGE-1];
endmodule

// File: tb/tb_ex_wb_dest_pipe.sv
// tb_ex_wb_dest_pipe: directed and random checks of ex_wb_dest_pipe against a slot-queue scoreboard.
module tb_ex_wb_dest_pipe;
   localparam int AW = 5;
   localparam int N  = 3;
   logic          clk = 1'b0;
   logic          rst_n, issue_valid, regwrite, stall, flush;
   logic [1:0]    dst_sel;
   logic [AW-1:0] rt, rd, id_rs, id_rt, ex_wbadd, wbadd;
   logic          wb_en;
   logic [N-1:0]  hit_rs, hit_rt;
   typedef struct packed {
      logic [AW-1:0] addr;
      logic          wr;
   } ent_t;
   ent_t pq[$];
   int n_chk = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   ex_wb_dest_pipe #(.REG_AW(AW), .NSTAGE(N), .LINK_REG(31)) dut (
      .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .regwrite(regwrite),
      .dst_sel(dst_sel), .rt(rt), .rd(rd), .stall(stall), .flush(flush),
      .id_rs(id_rs), .id_rt(id_rt), .ex_wbadd(ex_wbadd), .wbadd(wbadd),
      .wb_en(wb_en), .hit_rs(hit_rs), .hit_rt(hit_rt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic logic [AW-1:0] f_sel(input logic [1:0] ds, input logic [AW-1:0] a_rt, input logic [AW-1:0] a_rd);
      if (ds == 2'b01) return a_rd;
`ifdef LINK_DEST_EN
      if (ds == 2'b10) return 5'd31;
`endif
      return a_rt;
   endfunction

   function automatic logic f_wr(input logic iv, input logic rw, input logic [1:0] ds, input logic [AW-1:0] a);
`ifdef LINK_DEST_EN
      return iv && rw && ds != 2'b11 && a != 0;
`else
      return iv && rw && ds[1] == 1'b0 && a != 0;
`endif
   endfunction

   function automatic logic [N-1:0] f_hits(input logic [AW-1:0] src);
      logic [N-1:0] h = '0;
      for (int i = 0; i < N; i++) h[i] = pq[i].wr && pq[i].addr == src && src != 0;
      return h;
   endfunction

   task automatic step(input logic iv, input logic rw, input logic [1:0] ds, input logic [AW-1:0] a_rt,
                       input logic [AW-1:0] a_rd, input logic st, input logic fl, input logic rn);
      ent_t e, gone;
      issue_valid = iv; regwrite = rw; dst_sel = ds; rt = a_rt; rd = a_rd;
      stall = st; flush = fl; rst_n = rn;
      #1;
      chk("ex_wbadd", ex_wbadd, f_sel(ds, a_rt, a_rd));
      @(posedge clk);
      e.addr = f_sel(ds, a_rt, a_rd);
      e.wr   = f_wr(iv, rw, ds, e.addr);
      if (!rn) begin
         for (int i = 0; i < N; i++) pq[i] = '0;
      end else if (st) begin
         if (fl) pq[0] = '0;
      end else begin
         pq.push_front(fl ? ent_t'('0) : e);
         gone = pq.pop_back();
      end
      @(negedge clk);
      chk("wbadd", wbadd, pq[N-1].addr);
      chk("wb_en", wb_en, pq[N-1].wr);
      chk("hit_rs", hit_rs, f_hits(id_rs));
      chk("hit_rt", hit_rt, f_hits(id_rt));
   endtask

   task automatic idle();
      step(0, 0, 2'b00, 0, 0, 0, 0, 1);
   endtask

   initial begin
      for (int i = 0; i < N; i++) pq.push_back('0);
      id_rs = 0; id_rt = 0;
      step(0, 0, 2'b00, 0, 0, 0, 0, 0);
      step(0, 0, 2'b00, 0, 0, 0, 0, 0);
      chk("rst_wb_en", wb_en, 0);
      chk("rst_wbadd", wbadd, 0);
      // capture rd=9, visible two edges later
      step(1, 1, 2'b01, 0, 9, 0, 0, 1);
      chk("lat0_wb_en", wb_en, 0);
      idle();
      chk("lat1_wb_en", wb_en, 0);
      idle();
      chk("lat2_wbadd", wbadd, 9);
      chk("lat2_wb_en", wb_en, 1);
      step(1, 1, 2'b10, 4, 0, 0, 0, 1);
      idle();
      idle();
`ifdef LINK_DEST_EN
      chk("link_wbadd", wbadd, 31);
      chk("link_wb_en", wb_en, 1);
`else
      chk("link_wb_en", wb_en, 0);
`endif
      step(1, 1, 2'b00, 0, 8, 0, 0, 1);
      chk("r0_hit_rt", hit_rt, 0);
      idle();
      idle();
      chk("r0_wb_en", wb_en, 0);
      id_rs = 7;
      step(1, 1, 2'b01, 0, 7, 0, 0, 1);
      chk("stall_hit0", hit_rs, 3'b001);
      step(1, 1, 2'b01, 0, 7, 1, 0, 1);
      chk("stall_hit1", hit_rs, 3'b001);
      step(1, 1, 2'b01, 0, 7, 1, 0, 1);
      chk("stall_hit2", hit_rs, 3'b001);
      idle();
      chk("stall_early", wb_en, 0);
      idle();
      chk("stall_wbadd", wbadd, 7);
      chk("stall_wb_en", wb_en, 1);
      id_rs = 0;
      step(1, 1, 2'b01, 0, 5, 0, 0, 1);
      step(1, 1, 2'b01, 0, 6, 0, 1, 1);
      idle();
      chk("flush_keep", wbadd, 5);
      chk("flush_keep_en", wb_en, 1);
      idle();
      chk("flush_kill", wb_en, 0);
      step(1, 1, 2'b01, 0, 12, 0, 0, 1);
      step(1, 1, 2'b01, 0, 13, 0, 0, 1);
      step(1, 1, 2'b01, 0, 14, 1, 1, 1);
      idle();
      chk("fs_hold_old", wbadd, 12);
      idle();
      chk("fs_kill_young", wb_en, 0);
      id_rs = 3;
      step(1, 1, 2'b01, 0, 3, 0, 0, 1);
      step(1, 1, 2'b01, 0, 3, 0, 0, 1);
      chk("b2b_hit_rs", hit_rs, 3'b011);
      step(1, 1, 2'b01, 0, 3, 0, 0, 0);
      chk("mid_rst_hit", hit_rs, 0);
      chk("mid_rst_wb", {wbadd, wb_en}, 0);
      for (int k = 0; k < 300; k++) begin
         id_rs = AW'($urandom_range(0, 7));
         id_rt = AW'($urandom_range(0, 7));
         step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, 2'($urandom_range(0, 3)),
              AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
              $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 29) != 0);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
